reorder_buffer: RTL and testbench

- In-order retirement buffer for the out-of-order core.
- Sits between issue/dispatch (upstream: allocates one entry per issued instruction carrying a destination register) and the register file (downstream: receives in-order commits).
- Execution units write results back by ROB index.
- Operand forwarding reads completed results by ROB index. This is the 4-bit index carried in the forwarding info (A/B_fwd_rob_idx).

---
 rtl/reorder_buffer.sv | 178 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, accepts out-of-order writebacks by index,
// retires completed entries from head. Optional macro ROB_WB_BYPASS_EN forwards writebacks.
module reorder_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,

  input  logic             alloc_req,
  input  logic [31:0]      alloc_pc,
  input  logic [4:0]       alloc_dest_reg,
  input  logic             alloc_dest_reg_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,

  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_idx,
  input  logic [31:0]      wb_result_lo,
  input  logic [31:0]      wb_result_hi,

  input  logic [IDX_W-1:0] rd_a_idx,
  output logic             rd_a_ready,
  output logic [31:0]      rd_a_data,
  input  logic [IDX_W-1:0] rd_b_idx,
  output logic             rd_b_ready,
  output logic [31:0]      rd_b_data,

  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [4:0]       commit_dest_reg,
  output logic             commit_dest_reg_valid,
  output logic [31:0]      commit_result_lo,
  output logic [31:0]      commit_result_hi,

  input  logic             flush,
  output logic [IDX_W:0]   count,
  output logic             empty
);

  localparam int unsigned PTR_W = IDX_W + 1;

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;

  logic [31:0] pc_q        [DEPTH];
  logic [4:0]  dest_reg_q  [DEPTH];
  logic        dest_vld_q  [DEPTH];
  logic [31:0] result_lo_q [DEPTH];
  logic [31:0] result_hi_q [DEPTH];

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             full;
  logic             is_empty;
  logic             alloc_fire;
  logic             wb_hit;

  assign head_idx   = head_q[IDX_W-1:0];
  assign tail_idx   = tail_q[IDX_W-1:0];
  assign is_empty   = (head_q == tail_q);
  assign full       = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign alloc_ready = !full;
  assign alloc_idx  = tail_idx;
  assign alloc_fire = alloc_req && alloc_ready;
  assign wb_hit     = wb_valid && valid_q[wb_idx];
  assign empty      = is_empty;
  assign count      = count_q;

  // Commit sees only registered done, so a writeback to head retires next cycle at the earliest.
  assign commit_valid = !is_empty && done_q[head_idx];

  always_comb begin
    commit_pc             = '0;
    commit_dest_reg       = '0;
    commit_dest_reg_valid = 1'b0;
    commit_result_lo      = '0;
    commit_result_hi      = '0;
    if (commit_valid) begin
      commit_pc             = pc_q[head_idx];
      commit_dest_reg       = dest_reg_q[head_idx];
      commit_dest_reg_valid = dest_vld_q[head_idx];
      commit_result_lo      = result_lo_q[head_idx];
      commit_result_hi      = result_hi_q[head_idx];
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (wb_hit) begin
      done_d[wb_idx] = 1'b1;
    end
    if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + PTR_W'(1);
    end
    // Commit clears after writeback so a late duplicate writeback cannot revive a freed slot.
    if (commit_valid) begin
      valid_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
      head_d            = head_q + PTR_W'(1);
    end
    count_d = count_q + PTR_W'(alloc_fire) - PTR_W'(commit_valid);
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload storage is cleared on reset so every data output reads 0 afterwards.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]        <= '0;
        dest_reg_q[i]  <= '0;
        dest_vld_q[i]  <= 1'b0;
        result_lo_q[i] <= '0;
        result_hi_q[i] <= '0;
      end
    end else if (!flush) begin
      if (alloc_fire) begin
        pc_q[tail_idx]       <= alloc_pc;
        dest_reg_q[tail_idx] <= alloc_dest_reg;
        dest_vld_q[tail_idx] <= alloc_dest_reg_valid;
      end
      if (wb_hit) begin
        result_lo_q[wb_idx] <= wb_result_lo;
        result_hi_q[wb_idx] <= wb_result_hi;
      end
    end
  end

  always_comb begin
    rd_a_ready = valid_q[rd_a_idx] && done_q[rd_a_idx];
    rd_a_data  = result_lo_q[rd_a_idx];
    rd_b_ready = valid_q[rd_b_idx] && done_q[rd_b_idx];
    rd_b_data  = result_lo_q[rd_b_idx];
`ifdef ROB_WB_BYPASS_EN
    if (wb_hit && (wb_idx == rd_a_idx)) begin
      rd_a_ready = 1'b1;
      rd_a_data  = wb_result_lo;
    end
    if (wb_hit && (wb_idx == rd_b_idx)) begin
      rd_b_ready = 1'b1;
      rd_b_data  = wb_result_lo;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a cycle table for allocate/writeback/commit ordering,
// then hand sequences for bypass timing, unallocated writeback, full/wrap, reset and flush.
module tb_reorder_buffer;

  logic        clock;
  logic        reset_n;
  logic        alloc_req;
  logic [31:0] alloc_pc;
  logic [4:0]  alloc_dest_reg;
  logic        alloc_dest_reg_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_idx;
  logic        wb_valid;
  logic [3:0]  wb_idx;
  logic [31:0] wb_result_lo;
  logic [31:0] wb_result_hi;
  logic [3:0]  rd_a_idx;
  logic        rd_a_ready;
  logic [31:0] rd_a_data;
  logic [3:0]  rd_b_idx;
  logic        rd_b_ready;
  logic [31:0] rd_b_data;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [4:0]  commit_dest_reg;
  logic        commit_dest_reg_valid;
  logic [31:0] commit_result_lo;
  logic [31:0] commit_result_hi;
  logic        flush;
  logic [4:0]  count;
  logic        empty;

  int n_pass  = 0;
  int n_total = 0;

  reorder_buffer #(.DEPTH(16), .IDX_W(4)) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .alloc_req             (alloc_req),
    .alloc_pc              (alloc_pc),
    .alloc_dest_reg        (alloc_dest_reg),
    .alloc_dest_reg_valid  (alloc_dest_reg_valid),
    .alloc_ready           (alloc_ready),
    .alloc_idx             (alloc_idx),
    .wb_valid              (wb_valid),
    .wb_idx                (wb_idx),
    .wb_result_lo          (wb_result_lo),
    .wb_result_hi          (wb_result_hi),
    .rd_a_idx              (rd_a_idx),
    .rd_a_ready            (rd_a_ready),
    .rd_a_data             (rd_a_data),
    .rd_b_idx              (rd_b_idx),
    .rd_b_ready            (rd_b_ready),
    .rd_b_data             (rd_b_data),
    .commit_valid          (commit_valid),
    .commit_pc             (commit_pc),
    .commit_dest_reg       (commit_dest_reg),
    .commit_dest_reg_valid (commit_dest_reg_valid),
    .commit_result_lo      (commit_result_lo),
    .commit_result_hi      (commit_result_hi),
    .flush                 (flush),
    .count                 (count),
    .empty                 (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        a_req;
    logic [31:0] a_pc;
    logic [4:0]  a_dest;
    logic        wb_v;
    logic [3:0]  wb_i;
    logic [31:0] wb_lo;
    logic [31:0] wb_hi;
    logic [3:0]  rd_a;
    logic        e_ready;
    logic [3:0]  e_aidx;
    logic        e_cv;
    logic [31:0] e_cpc;
    logic [4:0]  e_cdest;
    logic [31:0] e_clo;
    logic [31:0] e_chi;
    logic [4:0]  e_count;
    logic        e_rdy_a;
    logic [31:0] e_dat_a;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle();
    alloc_req = 0; alloc_pc = '0; alloc_dest_reg = '0; alloc_dest_reg_valid = 0;
    wb_valid = 0; wb_idx = '0; wb_result_lo = '0; wb_result_hi = '0;
    rd_a_idx = '0; rd_b_idx = '0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [4:0] dest);
    alloc_req = 1; alloc_pc = pc; alloc_dest_reg = dest; alloc_dest_reg_valid = 1;
  endtask

  initial begin
    vt[0] = '{1, 32'h100, 5'd1, 0, 4'd0, 32'h0, 32'h0, 4'd0,
              1, 4'd0, 0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 0, 32'h0};
    vt[1] = '{1, 32'h104, 5'd2, 0, 4'd0, 32'h0, 32'h0, 4'd0,
              1, 4'd1, 0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd1, 0, 32'h0};
    vt[2] = '{1, 32'h108, 5'd3, 0, 4'd0, 32'h0, 32'h0, 4'd0,
              1, 4'd2, 0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd2, 0, 32'h0};
    vt[3] = '{0, 32'h0, 5'd0, 1, 4'd1, 32'hAAAA, 32'h1, 4'd0,
              1, 4'd3, 0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd3, 0, 32'h0};
    vt[4] = '{0, 32'h0, 5'd0, 1, 4'd0, 32'h5555, 32'h2, 4'd1,
              1, 4'd3, 0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd3, 1, 32'hAAAA};
    vt[5] = '{0, 32'h0, 5'd0, 0, 4'd0, 32'h0, 32'h0, 4'd0,
              1, 4'd3, 1, 32'h100, 5'd1, 32'h5555, 32'h2, 5'd3, 1, 32'h5555};
    vt[6] = '{0, 32'h0, 5'd0, 0, 4'd0, 32'h0, 32'h0, 4'd2,
              1, 4'd3, 1, 32'h104, 5'd2, 32'hAAAA, 32'h1, 5'd2, 0, 32'h0};
    vt[7] = '{0, 32'h0, 5'd0, 0, 4'd0, 32'h0, 32'h0, 4'd2,
              1, 4'd3, 0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd1, 0, 32'h0};

    do_reset();
    #1;
    chk("reset count", 32'(count), 0);
    chk("reset empty", 32'(empty), 1);
    chk("reset alloc_ready", 32'(alloc_ready), 1);
    chk("reset alloc_idx", 32'(alloc_idx), 0);
    chk("reset commit_valid", 32'(commit_valid), 0);
    chk("reset rd_a_ready", 32'(rd_a_ready), 0);
    chk("reset rd_b_data", rd_b_data, 0);
    chk("reset commit_pc", commit_pc, 0);

    // Allocate three, complete out of order, retire in order.
    for (int i = 0; i < 8; i++) begin
      idle();
      if (vt[i].a_req) alloc(vt[i].a_pc, vt[i].a_dest);
      wb_valid = vt[i].wb_v; wb_idx = vt[i].wb_i;
      wb_result_lo = vt[i].wb_lo; wb_result_hi = vt[i].wb_hi;
      rd_a_idx = vt[i].rd_a; rd_b_idx = vt[i].rd_a;
      #1;
      chk($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(vt[i].e_ready));
      chk($sformatf("v%0d alloc_idx", i), 32'(alloc_idx), 32'(vt[i].e_aidx));
      chk($sformatf("v%0d commit_valid", i), 32'(commit_valid), 32'(vt[i].e_cv));
      chk($sformatf("v%0d commit_pc", i), commit_pc, vt[i].e_cpc);
      chk($sformatf("v%0d commit_dest", i), 32'(commit_dest_reg), 32'(vt[i].e_cdest));
      chk($sformatf("v%0d commit_dvld", i), 32'(commit_dest_reg_valid), 32'(vt[i].e_cv));
      chk($sformatf("v%0d commit_lo", i), commit_result_lo, vt[i].e_clo);
      chk($sformatf("v%0d commit_hi", i), commit_result_hi, vt[i].e_chi);
      chk($sformatf("v%0d count", i), 32'(count), 32'(vt[i].e_count));
      chk($sformatf("v%0d rd_a_ready", i), 32'(rd_a_ready), 32'(vt[i].e_rdy_a));
      chk($sformatf("v%0d rd_a_data", i), rd_a_data, vt[i].e_dat_a);
      chk($sformatf("v%0d rd_b_ready", i), 32'(rd_b_ready), 32'(vt[i].e_rdy_a));
      tick();
    end

    // Same-cycle writeback/read of pending entry 2.
    idle();
    wb_valid = 1; wb_idx = 4'd2; wb_result_lo = 32'h1234; wb_result_hi = 32'h9;
    rd_a_idx = 4'd2;
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("bypass rd_a_ready", 32'(rd_a_ready), 1);
    chk("bypass rd_a_data", rd_a_data, 32'h1234);
`else
    chk("bypass rd_a_ready", 32'(rd_a_ready), 0);
    chk("bypass rd_a_data", rd_a_data, 0);
`endif
    chk("wb head no commit", 32'(commit_valid), 0);
    tick();
    idle();
    rd_a_idx = 4'd2;
    #1;
    chk("post-wb rd_a_ready", 32'(rd_a_ready), 1);
    chk("post-wb rd_a_data", rd_a_data, 32'h1234);
    chk("e2 commit_valid", 32'(commit_valid), 1);
    chk("e2 commit_pc", commit_pc, 32'h108);
    chk("e2 commit_dest", 32'(commit_dest_reg), 3);
    tick();
    #1;
    chk("drained count", 32'(count), 0);
    chk("drained empty", 32'(empty), 1);

    // Writeback to an unallocated index is ignored.
    idle();
    wb_valid = 1; wb_idx = 4'd5; wb_result_lo = 32'hBEEF;
    rd_a_idx = 4'd5;
    #1;
    chk("unalloc wb rd_a_ready same", 32'(rd_a_ready), 0);
    tick();
    idle();
    rd_a_idx = 4'd5;
    #1;
    chk("unalloc wb rd_a_ready", 32'(rd_a_ready), 0);
    chk("unalloc wb commit_valid", 32'(commit_valid), 0);
    chk("unalloc wb count", 32'(count), 0);

    // Fill to 16, refuse the 17th, retire one, wrap allocation to index 0.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle();
      alloc(32'h200 + 32'(4 * i), 5'(i));
      #1;
      chk($sformatf("fill alloc_idx %0d", i), 32'(alloc_idx), i);
      tick();
    end
    idle();
    #1;
    chk("full count", 32'(count), 16);
    chk("full alloc_ready", 32'(alloc_ready), 0);
    alloc(32'hDEAD, 5'd9);
    tick();
    idle();
    #1;
    chk("17th ignored count", 32'(count), 16);
    chk("17th ignored alloc_idx", 32'(alloc_idx), 0);
    wb_valid = 1; wb_idx = 4'd0; wb_result_lo = 32'h77;
    tick();
    idle();
    alloc(32'h300, 5'd4);
    #1;
    chk("full commit_valid", 32'(commit_valid), 1);
    chk("full commit_pc", commit_pc, 32'h200);
    chk("full refuses while committing", 32'(alloc_ready), 0);
    tick();
    idle();
    #1;
    chk("after commit count", 32'(count), 15);
    chk("after commit alloc_ready", 32'(alloc_ready), 1);
    chk("wrap alloc_idx", 32'(alloc_idx), 0);
    chk("after commit no commit", 32'(commit_valid), 0);
    alloc(32'h300, 5'd4);
    tick();
    idle();
    #1;
    chk("wrap refill count", 32'(count), 16);
    chk("wrap refill alloc_ready", 32'(alloc_ready), 0);
    chk("wrap refill alloc_idx", 32'(alloc_idx), 1);

    // Reset mid-operation discards the full buffer.
    wb_valid = 1; wb_idx = 4'd1;
    reset_n = 0;
    tick();
    reset_n = 1;
    idle();
    rd_a_idx = 4'd0;
    #1;
    chk("midreset count", 32'(count), 0);
    chk("midreset empty", 32'(empty), 1);
    chk("midreset rd_a_ready", 32'(rd_a_ready), 0);
    chk("midreset rd_a_data", rd_a_data, 0);
    chk("midreset commit_valid", 32'(commit_valid), 0);

    // Flush with six in flight overrides same-cycle alloc and writeback.
    for (int i = 0; i < 6; i++) begin
      idle();
      alloc(32'h400 + 32'(4 * i), 5'(i + 1));
      tick();
    end
    idle();
    wb_valid = 1; wb_idx = 4'd0; wb_result_lo = 32'h11;
    tick();
    idle();
    alloc(32'h500, 5'd7);
    wb_valid = 1; wb_idx = 4'd1; wb_result_lo = 32'h22;
    flush = 1;
    #1;
    chk("flush cycle count", 32'(count), 6);
    chk("flush cycle commit_valid", 32'(commit_valid), 1);
    tick();
    idle();
    rd_a_idx = 4'd1;
    #1;
    chk("flush count", 32'(count), 0);
    chk("flush empty", 32'(empty), 1);
    chk("flush alloc_idx", 32'(alloc_idx), 0);
    chk("flush alloc_ready", 32'(alloc_ready), 1);
    chk("flush commit_valid", 32'(commit_valid), 0);
    chk("flush rd_a_ready", 32'(rd_a_ready), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
